// File: rtl/amp_meter_pkg.sv
// Shared types, default sizing and threshold helper for the N-channel amplitude meter.
package amp_meter_pkg;

  localparam int DEF_NCH     = 2;
  localparam int DEF_AUD_W   = 16;
  localparam int DEF_LOG2L   = 3;
  localparam int DEF_THERM_W = 9;
  localparam int DEF_DECAY   = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_UPDATE
  } state_t;

  // Thermometer bit k lights at 2^(AUD_W-1-THERM_W+k): one bar segment per octave.
  function automatic logic [63:0] thresh(input int aud_w, input int therm_w, input int k);
    return 64'd1 << (aud_w - 1 - therm_w + k);
  endfunction

endpackage

// File: rtl/amp_meter_nch_log_therm.sv
// Log-scale thermometer encoder: average magnitude to a THERM_W-bit bar code.
module log_therm
  import amp_meter_pkg::*;
#(
  parameter int AUD_W   = DEF_AUD_W,
  parameter int THERM_W = DEF_THERM_W
) (
  input  logic [AUD_W-2:0]   avg,
  output logic [THERM_W-1:0] therm
);

  for (genvar k = 0; k < THERM_W; k++) begin : g_bit
    localparam logic [63:0] TH = thresh(AUD_W, THERM_W, k);
    assign therm[k] = (64'(avg) >= TH);
  end

endmodule

// File: rtl/amp_meter_nch.sv
// N-channel amplitude meter: one abs/average/thermometer datapath time-shared
// across channels per frame, with optional peak-hold display and decay.
module amp_meter_nch
  import amp_meter_pkg::*;
#(
  parameter int NCH     = DEF_NCH,
  parameter int AUD_W   = DEF_AUD_W,
  parameter int LOG2L   = DEF_LOG2L,
  parameter int THERM_W = DEF_THERM_W,
  parameter int DECAY   = DEF_DECAY
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   aud_vld,
  input  logic [NCH*AUD_W-1:0]   aud,
  input  logic                   peak_mode,
  output logic [NCH*THERM_W-1:0] amp,
  output logic                   busy,
  output logic                   done,
  output logic                   ovr
);

  localparam int MAG_W  = AUD_W - 1;
  localparam int ACC_W  = MAG_W + LOG2L;
  localparam int PROD_W = ACC_W + LOG2L;
  localparam int IDX_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_W  = (DECAY > 1) ? $clog2(DECAY) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NCH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DECAY - 1);
  localparam logic [PROD_W-1:0] KEEP     = PROD_W'((1 << LOG2L) - 1);

  state_t                         state;
  logic [IDX_W-1:0]               idx;
  logic [NCH-1:0][AUD_W-1:0]      aud_q;
  logic                           peak_q;
  logic [NCH-1:0][ACC_W-1:0]      acc_q;
  logic [NCH-1:0][THERM_W-1:0]    amp_q;
  logic [NCH-1:0][CNT_W-1:0]      cnt_q;

  logic [AUD_W-1:0]   sample;
  logic [AUD_W-1:0]   neg;
  logic [MAG_W-1:0]   mag;
  logic [ACC_W-1:0]   acc_cur;
  logic [ACC_W-1:0]   acc_next;
  logic [PROD_W-1:0]  prod;
  logic [MAG_W-1:0]   avg;
  logic [THERM_W-1:0] therm;
  logic [THERM_W-1:0] amp_cur;
  logic [THERM_W-1:0] amp_next;
  logic [CNT_W-1:0]   cnt_cur;
  logic [CNT_W-1:0]   cnt_next;
  logic               tick;
  logic [NCH-1:0]     acc_en;
  logic [NCH-1:0]     amp_en;

  // NOTE: every branch below assigns every output, so this stays combinational with no latch.
  always_comb begin
    sample = aud_q[idx];
    neg    = ~sample + AUD_W'(1);
    if (!sample[AUD_W-1])    mag = sample[MAG_W-1:0];
    else if (neg[AUD_W-1])   mag = '1;  // most-negative sample saturates to full scale
    else                     mag = neg[MAG_W-1:0];

    acc_cur  = acc_q[idx];
    prod     = PROD_W'(acc_cur) * KEEP;
    acc_next = ACC_W'(prod >> LOG2L) + ACC_W'(mag);
    avg      = acc_cur[ACC_W-1:LOG2L];

    cnt_cur  = cnt_q[idx];
    tick     = (cnt_cur == CNT_MAX);
    cnt_next = tick ? '0 : cnt_cur + CNT_W'(1);
    amp_cur  = amp_q[idx];
    amp_next = peak_q ? ((tick ? (amp_cur >> 1) : amp_cur) | therm) : therm;

    acc_en = '0;
    amp_en = '0;
    for (int c = 0; c < NCH; c++) begin
      acc_en[c] = (state == ST_ACCUM)  && (idx == IDX_W'(c));
      amp_en[c] = (state == ST_UPDATE) && (idx == IDX_W'(c));
    end
  end

  log_therm #(
    .AUD_W  (AUD_W),
    .THERM_W(THERM_W)
  ) u_therm (
    .avg  (avg),
    .therm(therm)
  );

  // NOTE: the per-channel arrays are true state (averages, displayed codes, decay phase),
  // so they take the async reset rather than being left as uninitialised storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      amp_q <= '0;
      cnt_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (acc_en[c]) acc_q[c] <= acc_next;
        if (amp_en[c]) begin
          amp_q[c] <= amp_next;
          cnt_q[c] <= cnt_next;
        end
      end
    end
  end

  // NOTE: non-blocking assignments throughout, so every register here sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      aud_q  <= '0;
      peak_q <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      done <= 1'b0;
      ovr  <= aud_vld && (state != ST_IDLE);
      unique case (state)
        ST_IDLE: begin
          if (aud_vld) begin
            aud_q  <= aud;
            peak_q <= peak_mode;
            idx    <= '0;
            state  <= ST_ACCUM;
            busy   <= 1'b1;
          end
        end
        ST_ACCUM: state <= ST_UPDATE;
        ST_UPDATE: begin
          if (idx == LAST_IDX) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= ST_ACCUM;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign amp = amp_q;

endmodule

// File: tb/tb_amp_meter_nch.sv
// Scoreboard bench for amp_meter_nch: a 2-channel (DECAY=4) and a 4-channel (LOG2L=4) build.
module tb_amp_meter_nch;

  localparam int AW = 16;
  localparam int TW = 9;
  localparam int NA = 2, LA = 3, DA = 4;
  localparam int NB = 4, LB = 4, DB = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  logic              vld_a = 1'b0, peak_a = 1'b0;
  logic [NA*AW-1:0]  aud_a = '0;
  logic [NA*TW-1:0]  amp_a;
  logic              busy_a, done_a, ovr_a;

  logic              vld_b = 1'b0, peak_b = 1'b0;
  logic [NB*AW-1:0]  aud_b = '0;
  logic [NB*TW-1:0]  amp_b;
  logic              busy_b, done_b, ovr_b;

  amp_meter_nch #(.NCH(NA), .AUD_W(AW), .LOG2L(LA), .THERM_W(TW), .DECAY(DA)) dut_a (
    .clk(clk), .rst_n(rst_n), .aud_vld(vld_a), .aud(aud_a), .peak_mode(peak_a),
    .amp(amp_a), .busy(busy_a), .done(done_a), .ovr(ovr_a)
  );

  amp_meter_nch #(.NCH(NB), .AUD_W(AW), .LOG2L(LB), .THERM_W(TW), .DECAY(DB)) dut_b (
    .clk(clk), .rst_n(rst_n), .aud_vld(vld_b), .aud(aud_b), .peak_mode(peak_b),
    .amp(amp_b), .busy(busy_b), .done(done_b), .ovr(ovr_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ovr_cnt_a = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: integer arithmetic per channel.
  longint acc_ma[NA];
  int     amp_ma[NA], cnt_ma[NA];
  longint acc_mb[NB];
  int     amp_mb[NB], cnt_mb[NB];

  function automatic int ref_mag(input logic [AW-1:0] s);
    int v;
    v = int'($signed(s));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  function automatic int ref_therm(input longint avg);
    int t;
    t = 0;
    for (int k = 0; k < TW; k++)
      if (avg >= (longint'(1) << (6 + k))) t = t | (1 << k);
    return t;
  endfunction

  task automatic ref_ch(input int log2l, input int decay, input logic [AW-1:0] s, input bit peak,
                        inout longint acc, inout int amp, inout int cnt);
    longint l;
    int     th;
    bit     tk;
    l   = longint'(1) << log2l;
    acc = (acc * (l - 1)) / l + longint'(ref_mag(s));
    th  = ref_therm(acc / l);
    tk  = (cnt == decay - 1);
    cnt = tk ? 0 : cnt + 1;
    amp = peak ? ((tk ? amp / 2 : amp) | th) : th;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NA; c++) begin acc_ma[c] = 0; amp_ma[c] = 0; cnt_ma[c] = 0; end
    for (int c = 0; c < NB; c++) begin acc_mb[c] = 0; amp_mb[c] = 0; cnt_mb[c] = 0; end
  endtask

  typedef struct {
    logic [35:0] amp;
    int          issue;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic push_a(input logic [AW-1:0] s0, input logic [AW-1:0] s1, input bit peak);
    exp_t e;
    ref_ch(LA, DA, s0, peak, acc_ma[0], amp_ma[0], cnt_ma[0]);
    ref_ch(LA, DA, s1, peak, acc_ma[1], amp_ma[1], cnt_ma[1]);
    e.amp   = 36'({TW'(amp_ma[1]), TW'(amp_ma[0])});
    e.issue = cyc;
    q_a.push_back(e);
  endtask

  task automatic push_b(input logic [NB*AW-1:0] s, input bit peak);
    exp_t e;
    e.amp = '0;
    for (int c = 0; c < NB; c++) begin
      ref_ch(LB, DB, s[c*AW +: AW], peak, acc_mb[c], amp_mb[c], cnt_mb[c]);
      e.amp[c*TW +: TW] = TW'(amp_mb[c]);
    end
    e.issue = cyc;
    q_b.push_back(e);
  endtask

  // Issues one frame and returns #1 after edge issue+gap-1; next call issues gap cycles later.
  task automatic send_a(input logic [AW-1:0] s0, input logic [AW-1:0] s1, input bit peak, input int gap);
    @(posedge clk); #1;
    aud_a  = {s1, s0};
    peak_a = peak;
    vld_a  = 1'b1;
    push_a(s0, s1, peak);
    @(posedge clk); #1;
    vld_a = 1'b0;
    repeat (gap - 2) @(posedge clk);
    #1;
  endtask

  task automatic send_b(input logic [NB*AW-1:0] s, input bit peak, input int gap);
    @(posedge clk); #1;
    aud_b  = s;
    peak_b = peak;
    vld_b  = 1'b1;
    push_b(s, peak);
    @(posedge clk); #1;
    vld_b = 1'b0;
    repeat (gap - 2) @(posedge clk);
    #1;
  endtask

  // Monitors: pop and compare on every done pulse.
  initial forever begin
    exp_t e;
    @(posedge clk); #1;
    if (ovr_a) ovr_cnt_a++;
    if (done_a) begin
      if (q_a.size() == 0) check("a_done_without_frame", 64'(q_a.size()), 64'd1);
      else begin
        e = q_a.pop_front();
        check("a_amp", 64'(amp_a), 64'(e.amp[NA*TW-1:0]));
        check("a_latency", 64'(cyc - e.issue), 64'(2 * NA + 1));
      end
    end
  end

  initial forever begin
    exp_t e;
    @(posedge clk); #1;
    if (done_b) begin
      if (q_b.size() == 0) check("b_done_without_frame", 64'(q_b.size()), 64'd1);
      else begin
        e = q_b.pop_front();
        check("b_amp", 64'(amp_b), 64'(e.amp));
        check("b_latency", 64'(cyc - e.issue), 64'(2 * NB + 1));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  localparam logic [NB*AW-1:0] B_SAMPLES = {16'h0000, 16'h7FFF, 16'hF400, 16'h0180};

  initial begin
    int ovr_before;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_amp_a", 64'(amp_a), 64'd0);
    check("rst_busy_a", 64'(busy_a), 64'd0);
    check("rst_done_a", 64'(done_a), 64'd0);
    check("rst_ovr_a", 64'(ovr_a), 64'd0);
    check("rst_amp_b", 64'(amp_b), 64'd0);
    check("rst_busy_b", 64'(busy_b), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // First frame: avg0 = 16384>>3 = 2048 lights thresholds 64..2048.
    send_a(16'h4000, 16'h0000, 1'b0, 6);
    check("first_amp", 64'(amp_a), 64'h0003F);

    // Reset asserted while channel 0 is in UPDATE.
    @(posedge clk); #1;
    aud_a = {16'h0000, 16'h7FFF};
    vld_a = 1'b1;
    @(posedge clk); #1;
    vld_a = 1'b0;
    check("mid_busy", 64'(busy_a), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_amp", 64'(amp_a), 64'd0);
    check("mid_rst_busy", 64'(busy_a), 64'd0);
    check("mid_rst_done", 64'(done_a), 64'd0);
    model_reset();
    q_a.delete();
    q_b.delete();
    @(negedge clk) rst_n = 1'b1;

    send_a(16'h4000, 16'h0000, 1'b0, 6);
    check("first_again_amp", 64'(amp_a), 64'h0003F);

    // Full-negative saturation on ch1, frames back to back at the minimum period.
    ovr_before = ovr_cnt_a;
    for (int i = 0; i < 200; i++) send_a(16'h0000, 16'h8000, 1'b0, 5);
    repeat (2) @(posedge clk);
    #1;
    check("sat_amp1", 64'(amp_a[2*TW-1:TW]), 64'h1FF);
    check("sat_no_ovr", 64'(ovr_cnt_a - ovr_before), 64'd0);

    // Peak hold: fill, then silence lets the held code decay.
    for (int i = 0; i < 100; i++) send_a(16'h7FFF, 16'h0000, 1'b1, 6);
    check("peak_full_amp0", 64'(amp_a[TW-1:0]), 64'h1FF);
    for (int i = 0; i < 40; i++) send_a(16'h0000, 16'h0000, 1'b1, 6);
    for (int i = 0; i < 3; i++) send_a(16'h0000, 16'h0000, 1'b0, 6);

    // Overrun: second strobe two cycles after the first is dropped.
    ovr_before = ovr_cnt_a;
    @(posedge clk); #1;
    aud_a  = {16'h2000, 16'h0400};
    peak_a = 1'b0;
    vld_a  = 1'b1;
    push_a(16'h0400, 16'h2000, 1'b0);
    @(posedge clk); #1;
    vld_a = 1'b0;
    @(posedge clk); #1;
    aud_a = {16'h7FFF, 16'h7FFF};
    vld_a = 1'b1;
    @(posedge clk); #1;
    vld_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("ovr_pulses", 64'(ovr_cnt_a - ovr_before), 64'd1);
    send_a(16'h1234, 16'hFF00, 1'b0, 6);

    // Four-channel build: distinct constant per channel.
    send_b(B_SAMPLES, 1'b0, 10);
    check("b_first_amp", 64'(amp_b), 64'h0007C0600);
    for (int i = 0; i < 200; i++) send_b(B_SAMPLES, 1'b0, 9);
    repeat (2) @(posedge clk);
    #1;
    check("b_steady_amp", 64'(amp_b), 64'h007FC7E07);
    for (int i = 0; i < 10; i++) send_b(B_SAMPLES, 1'b1, 9);

    for (int i = 0; i < 100 && (q_a.size() != 0 || q_b.size() != 0); i++) @(posedge clk);
    #2;
    check("queues_drained", 64'(q_a.size() + q_b.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/amp_meter_nch.md
# amp_meter_nch

Parametrised N-channel audio amplitude meter that replaces the fixed two-channel averager in the LED display path. On each valid sample frame it time-shares one abs/average/thermometer datapath across NCH channels, sequenced by a state machine. Each channel keeps an exponential average with configurable depth 2^LOG2L. The block adds an optional peak-hold display mode with programmable decay. Per-channel thermometer codes drive the amplitude LED bars.

## Interface
- NCH, 2, number of audio channels (≥1); channel 0 = left, 1 = right
- AUD_W, 16, signed sample width
- LOG2L, 3, log2 of averaging depth L
- THERM_W, 9, thermometer code width (≤ AUD_W-1)
- DECAY, 64, channel updates between peak-hold decay steps (≥1)
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- aud_vld  in  1  one-cycle strobe, new frame on aud
- aud  in  NCH*AUD_W  packed signed samples, channel c at [c*AUD_W +: AUD_W]
- peak_mode  in  1  0 = average display, 1 = peak-hold display
- amp  out  NCH*THERM_W  packed thermometer codes, channel c at [c*THERM_W +: THERM_W]
- busy  out  1  high while sequencing a frame
- done  out  1  one-cycle pulse, all channels updated
- ovr  out  1  one-cycle pulse, aud_vld arrived while busy (frame dropped)

## Operation
- States:
  - IDLE: waits for aud_vld.
  - ACCUM(c): writes the accumulator for channel c.
  - UPDATE(c): writes the display code for channel c.
- Transitions: IDLE→ACCUM(0) on aud_vld; ACCUM(c)→UPDATE(c); UPDATE(c)→ACCUM(c+1); UPDATE(NCH-1)→IDLE.
- Frame capture: on acceptance, aud and peak_mode are registered. All processing uses the captured copy, so input changes mid-frame are ignored.
- mag = |sample|, AUD_W-1 bits, saturating: -2^(AUD_W-1) → 2^(AUD_W-1)-1.
- Accumulator: width AUD_W-1+LOG2L, reset 0. ACCUM(c) computes acc[c] ← ((acc[c]*(2^LOG2L-1)) >> LOG2L) + mag.
  - Product is full width (no truncation before the shift).
  - The sum never overflows, since steady state is ≤ L*max mag.
- avg = acc[c] >> LOG2L (upper AUD_W-1 bits).
- Thermometer: bit k of therm = (avg ≥ 2^(AUD_W-1-THERM_W+k)), for k = 0..THERM_W-1. This gives a log scale; defaults use thresholds 64…16384.
- UPDATE(c), average mode: amp[c] ← therm.
- UPDATE(c), peak mode:
  - Per-channel decay counter, reset 0, increments every UPDATE(c) in either mode and wraps at DECAY-1.
  - tick = (count == DECAY-1).
  - amp[c] ← (tick ? amp[c]>>1 : amp[c]) | therm.
- Mode switch from peak to average takes effect on the next UPDATE(c) by plain overwrite.

## Timing
- Reset values: every amp, acc, decay counter, busy, done and ovr = 0; state = IDLE.
- aud_vld high in IDLE at cycle t:
  - capture and entry to ACCUM(0) at edge t+1;
  - acc[c] written at edge t+2+2c;
  - amp[c] written at edge t+3+2c.
- busy = (state ≠ IDLE), registered; high from edge t+1 through edge t+2*NCH+1 exclusive.
- done is high for the cycle after edge t+2*NCH+1, coincident with the return to IDLE. aud_vld in that cycle is accepted.
- aud_vld while busy: frame dropped, ovr high one cycle (registered), in-progress frame unaffected.
- Reset mid-frame: immediate return to reset values; no partial outputs survive.
- Frame period ≥ 2*NCH+1 cycles for lossless operation.

## Structure
- Package amp_meter_pkg:
  - state enum (IDLE, ACCUM, UPDATE) plus channel index register;
  - function thresh(k) for thermometer thresholds;
  - default parameter constants.
- Sub-module log_therm (avg → THERM_W code, purely combinational), shared across channels.
- Muxes index the packed aud, acc and amp arrays by the channel counter. There is one accumulator register array and one amp register array, each with a per-channel enable = state match & (idx == c).

## Test plan
- First frame, defaults: ch0 = 0x4000, ch1 = 0 → after done, acc0 = 16384, avg0 = 2048, amp[0] = 0x03F, amp[1] = 0x000. Done arrives exactly 5 cycles after aud_vld.
- Saturation/convergence: ch1 = 0x8000 held for 200 frames → acc1 settles at 8*32767 ± 7, amp[1] = 0x1FF. Cross-check against a reference model every frame.
- Peak hold, DECAY = 4: 100 frames of 0x7FFF, then silence → amp[0] decays 0x1FF→0x0FF→0x07F… one step per 4 frames. Never below the average-mode code.
- Overrun: second aud_vld 2 cycles after the first → ovr pulses once, first frame completes normally, second frame is not applied.
- Reset mid-frame: assert rst_n low during UPDATE(0) → all outputs 0 next cycle. The following frame behaves exactly as the first-frame case.
- NCH = 4, LOG2L = 4 build: distinct constant per channel → amp[c] matches the model, latency 2*NCH+1 = 9, no cross-channel leakage.
